uart_tx_sched: RTL

//   Scheduler that drains the UART TX FIFO into the UART transmitter, one word per frame.

---
 rtl/uart_tx_sched.sv | 129 ++++++++++++
 1 files changed

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_sched
// Drains the TX FIFO into the UART transmitter, one word per frame, with a
// programmable idle gap. Optional macro UART_TX_CTS_EN adds cts_ni gating.
// Rev     : 1.0
// ============================================================================
module uart_tx_sched #(
  parameter int WordLength = 8,
  parameter int GapCycles  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  fifo_empty_i,
  input  logic [WordLength-1:0] fifo_data_i,
  output logic                  fifo_rd_o,
  output logic                  tx_start_o,
  output logic [WordLength-1:0] tx_data_o,
  input  logic                  tx_done_i,
  output logic                  busy_o,
  output logic [15:0]           frame_cnt_o
`ifdef UART_TX_CTS_EN
  ,
  input  logic                  cts_ni
`endif
);

  localparam int GAP_W = (GapCycles > 0) ? $clog2(GapCycles + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GapCycles > 0) ? GAP_W'(GapCycles - 1) : '0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]            state;
  logic [2:0]            next_state;
  logic [GAP_W-1:0]      gap_cnt;
  logic [WordLength-1:0] tx_data;
  logic [15:0]           frame_cnt;
  logic                  cts_ok;

`ifdef UART_TX_CTS_EN
  // cts_ni is asynchronous to clk_i; resets to the blocked level
  logic [1:0] cts_sync;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cts_sync <= 2'b11;
    end else begin
      cts_sync <= {cts_sync[0], cts_ni};
    end
  end

  assign cts_ok = ~cts_sync[1];
`else
  assign cts_ok = 1'b1;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (en_i && !fifo_empty_i && cts_ok) begin
          next_state = S_LOAD;
        end
      end
      S_LOAD:  next_state = S_START;
      S_START: next_state = S_WAIT;
      S_WAIT: begin
        if (tx_done_i) begin
          next_state = (GapCycles == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_rd_o  = 1'b0;
    tx_start_o = 1'b0;
    busy_o     = 1'b1;
    case (state)
      S_IDLE:  busy_o     = 1'b0;
      S_LOAD:  fifo_rd_o  = 1'b1;
      S_START: tx_start_o = 1'b1;
      default: busy_o     = 1'b1;
    endcase
  end

  // Head word is still valid during LOAD; the pop lands at the end of it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_data   <= '0;
      frame_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      if (state == S_LOAD) begin
        tx_data <= fifo_data_i;
      end
      if (state == S_WAIT && tx_done_i) begin
        frame_cnt <= frame_cnt + 16'd1;
        gap_cnt   <= GAP_LOAD;
      end else if (state == S_GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

  assign tx_data_o   = tx_data;
  assign frame_cnt_o = frame_cnt;

endmodule
`default_nettype wire
